// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if
//  Bundles everything between the arbiter, its two requesters and the shared RAM
//  port. clk/nrst stay outside as plain ports.
//  slave  : arbiter view (commands + mem_dout in; ready/rsp/mem_*/busy out)
//  master : requester/RAM-side view (the mirror image)
//  req{0,1}_valid/we/addr/wdata  command from requester N, held until req{N}_ready
//  req{0,1}_ready                1-cycle accept pulse
//  rsp_valid/rsp_id/rsp_data     read response (rsp_data holds between responses)
//  mem_chipe/wre/addr/din        drive the RAM port
//  mem_dout                      registered RAM read data
//  busy                          arbiter not idle
interface ram_port_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic                  req0_valid;
  logic                  req0_we;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_wdata;
  logic                  req0_ready;
  logic                  req1_valid;
  logic                  req1_we;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_wdata;
  logic                  req1_ready;
  logic                  rsp_valid;
  logic                  rsp_id;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  mem_chipe;
  logic                  mem_wre;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;
  logic [DATA_WIDTH-1:0] mem_dout;
  logic                  busy;

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    input  mem_dout,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data,
    output mem_chipe, mem_wre, mem_addr, mem_din,
    output busy
  );

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    output mem_dout,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data,
    input  mem_chipe, mem_wre, mem_addr, mem_din,
    input  busy
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//  Round-robin arbiter sharing one synchronous RAM port between two requesters.
//  One single-word command in flight at a time:
//    IDLE  -> pick winner, register mem_* and pulse ready
//    ISSUE -> mem_chipe high for exactly one cycle, RAM acts at the closing edge
//    RESP  -> (reads only) mem_dout valid, registered into rsp_data
//  Every output is a flop; reset (synchronous, active low) clears them all.
//  Ports:
//    clk   single clock shared with the RAM port
//    nrst  synchronous active-low reset
//    bus   ram_port_arbiter_if.slave (requesters, response, RAM port, busy)
module ram_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 nrst,
  ram_port_arbiter_if.slave    bus
);

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } cmd_t;

  // requester inputs gathered into indexable form
  logic [NUM_REQ-1:0]  req_vld;
  cmd_t [NUM_REQ-1:0]  req_cmd;

  assign req_vld    = {bus.req1_valid, bus.req0_valid};
  assign req_cmd[0] = {bus.req0_we, bus.req0_addr, bus.req0_wdata};
  assign req_cmd[1] = {bus.req1_we, bus.req1_addr, bus.req1_wdata};

  // registered state and outputs
  state_t                state_q,     state_d;
  logic                  last_gnt_q,  last_gnt_d;
  logic                  gnt_id_q,    gnt_id_d;
  logic                  gnt_we_q,    gnt_we_d;
  logic [NUM_REQ-1:0]    ready_q,     ready_d;
  logic                  chipe_q,     chipe_d;
  logic                  wre_q,       wre_d;
  logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
  logic [DATA_WIDTH-1:0] din_q,       din_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_id_q,    rsp_id_d;
  logic [DATA_WIDTH-1:0] rsp_data_q,  rsp_data_d;
  logic                  busy_q,      busy_d;

  // winner: contention goes to whoever was not granted last, otherwise the
  // lone requester (req1 iff req0 is idle)
  logic win;
  assign win = (&req_vld) ? ~last_gnt_q : req_vld[1];

  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_we_d    = gnt_we_q;
    ready_d     = '0;
    chipe_d     = 1'b0;
    wre_d       = 1'b0;
    addr_d      = addr_q;
    din_d       = din_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;

    unique case (state_q)
      IDLE: begin
        if (|req_vld) begin
          addr_d       = req_cmd[win].addr;
          din_d        = req_cmd[win].wdata;
          wre_d        = req_cmd[win].we;
          chipe_d      = 1'b1;
          ready_d[win] = 1'b1;
          last_gnt_d   = win;
          gnt_id_d     = win;
          gnt_we_d     = req_cmd[win].we;
          state_d      = ISSUE;
        end
      end
      // chipe/wre/ready drop via defaults, so chipe can never stay high
      // across two cycles
      ISSUE: state_d = gnt_we_q ? IDLE : RESP;
      RESP: begin
        rsp_data_d  = bus.mem_dout;
        rsp_id_d    = gnt_id_q;
        rsp_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // busy is registered alongside the state it describes
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= IDLE;
      last_gnt_q  <= 1'b1;
      gnt_id_q    <= 1'b0;
      gnt_we_q    <= 1'b0;
      ready_q     <= '0;
      chipe_q     <= 1'b0;
      wre_q       <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_we_q    <= gnt_we_d;
      ready_q     <= ready_d;
      chipe_q     <= chipe_d;
      wre_q       <= wre_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.req0_ready = ready_q[0];
  assign bus.req1_ready = ready_q[1];
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.mem_chipe  = chipe_q;
  assign bus.mem_wre    = wre_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_din    = din_q;
  assign bus.busy       = busy_q;

endmodule
